riscv_dbus_ctrl: RTL and testbench
==================================

# riscv_dbus_ctrl

Data-bus controller for the MEM stage of the pipeline. It turns the MEM-stage load/store request into a req/gnt/rvalid transaction on the data bus, and aligns and sign-extends load data. It drives `o_bus_stallM` into the hazard unit, holding the pipeline until the access completes.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, 256: maximum cycles spent in REQ+WAIT before the access is aborted. Used only with the timeout feature; must be ≥ 2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_mem_reqM`  in  1  MEM-stage instruction is a load/store
- `i_mem_weM`  in  1  1 = store, 0 = load
- `i_mem_funct3M`  in  3  access size and sign (RV32I load/store funct3)
- `i_mem_addrM`  in  32  byte address
- `i_mem_wdataM`  in  32  store data, LSB-aligned
- `o_mem_rdataM`  out  32  aligned, extended load data; valid in DONE
- `o_bus_stallM`  out  1  stall request to the hazard unit
- `o_faultM`  out  1  misaligned or illegal access; 1-cycle pulse
- `o_bus_errM`  out  1  bus error or timeout; 1-cycle pulse in DONE
- `o_bus_req`  out  1  bus request
- `o_bus_we`  out  1  bus write
- `o_bus_addr`  out  32  word address; `[1:0]` = 0
- `o_bus_be`  out  4  byte enables
- `o_bus_wdata`  out  32  lane-replicated store data
- `i_bus_gnt`  in  1  request accepted
- `i_bus_rvalid`  in  1  response valid (read data or write ack)
- `i_bus_rdata`  in  32  read data
- `i_bus_err`  in  1  error; qualified by `i_bus_rvalid`

## Operation

- The FSM has four states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `i_mem_reqM` is high and the access is legal: register addr/we/be/wdata/funct3, then go to REQ.
  - If `i_mem_reqM` is high and the access is illegal: pulse `o_faultM`, issue no bus request, stay in IDLE.
- **REQ**
  - `o_bus_req` is 1.
  - The bus outputs stay stable until `i_bus_gnt` is high.
  - On gnt, go to WAIT.
  - `i_bus_rvalid` is ignored in this state.
- **WAIT**
  - `o_bus_req` is 0.
  - On `i_bus_rvalid`, capture `i_bus_rdata` and `i_bus_err`, then go to DONE.
- **DONE**
  - Stall is released.
  - `o_mem_rdataM` is valid and `o_bus_errM` reflects the captured error.
  - The next state is always IDLE.
- `o_bus_stallM` = `i_mem_reqM` & legal & (state != DONE). It is combinational.
- Legality rules:
  - LH/LHU/SH need `addr[0]` = 0.
  - LW/SW need `addr[1:0]` = 0.
  - Loads with funct3 011, 110 or 111 are illegal.
  - Stores with funct3 ≥ 011 are illegal.
- Byte enables:
  - Byte access: `4'b0001 << addr[1:0]`.
  - Half access: `4'b0011 << addr[1:0]`.
  - Word access: `4'b1111`.
- Store data: byte replicated ×4, half replicated ×2, word as is.
- Load extraction uses the selected lane:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: the full word.
- Stores also wait in WAIT for the rvalid ack. `o_mem_rdataM` is 0 for stores.
- An rvalid seen in IDLE or DONE is ignored. No outstanding accesses are supported beyond one.

## Timing

- Reset values:
  - state = IDLE.
  - `o_bus_req`, `o_bus_we`, `o_bus_errM`, `o_faultM` = 0.
  - `o_bus_addr`, `o_bus_be`, `o_bus_wdata`, `o_mem_rdataM` = 0.
- Minimum load/store latency (gnt in the first REQ cycle, rvalid the next cycle):
  - cycle 0 IDLE: stall 1
  - cycle 1 REQ: stall 1
  - cycle 2 WAIT: stall 1
  - cycle 3 DONE: stall 0, data valid
  - Total: 3 stall cycles.
- Each cycle without gnt in REQ, or without rvalid in WAIT, adds one stall cycle.
- Faults: `o_faultM` is high in the same cycle the illegal request is seen. Stall stays 0.
- Reset mid-transaction:
  - Next cycle: IDLE with `o_bus_req` = 0.
  - Any late rvalid is discarded.
- Back-to-back accesses: the instruction that follows enters IDLE the cycle after DONE and starts a new transaction there. There is no bubble beyond that.

## Configuration

- `RISCV_DBUS_TIMEOUT_EN` defined:
  - A counter runs in REQ+WAIT and clears on entering REQ.
  - When it reaches `TIMEOUT_CYCLES`, go to DONE with `o_bus_errM` = 1 and `o_mem_rdataM` = 0, and drop `o_bus_req`.
- `RISCV_DBUS_TIMEOUT_EN` undefined:
  - No counter.
  - REQ and WAIT wait indefinitely.

## Test plan

- LW at 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF:
  - `o_bus_addr` = 0x100, be = 1111.
  - Stall for 3 cycles, then `o_mem_rdataM` = 0xDEADBEEF.
- LB at 0x103 with rdata 0x80FF_0000 → be = 1000, `o_mem_rdataM` = 0xFFFFFF80. LBU on the same data → 0x00000080.
- SH at 0x102 with wdata 0x1234ABCD:
  - be = 1100, `o_bus_wdata` = 0xABCDABCD, we = 1.
  - Stall released after the rvalid ack.
- LW at 0x101 → `o_faultM` is high for 1 cycle, `o_bus_req` never rises, stall = 0.
- gnt held low for 5 cycles → bus outputs are stable for all 5 cycles, and stall is extended by exactly 5 cycles.
- Timeout, with `RISCV_DBUS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, and rvalid never arriving:
  - DONE after 8 cycles, with `o_bus_errM` = 1.
  - Then `rst` is asserted mid-WAIT → IDLE the next cycle, and a late rvalid is ignored.

Source files
------------

// File: rtl/riscv_dbus_ctrl_if.sv
// Data-bus signal bundle between the MEM-stage bus controller (master) and memory (slave).
interface riscv_dbus_ctrl_if;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_gnt;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;
  logic        i_bus_err;

  modport master (
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
    input  i_bus_gnt, i_bus_rvalid, i_bus_rdata, i_bus_err
  );

  modport slave (
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
    output i_bus_gnt, i_bus_rvalid, i_bus_rdata, i_bus_err
  );
endinterface

// File: rtl/riscv_dbus_ctrl.sv
// MEM-stage data-bus controller: req/gnt/rvalid transactions, lane alignment and load extension.
// Optional access timeout enabled by defining RISCV_DBUS_TIMEOUT_EN.
module riscv_dbus_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_reqM,
  input  logic        i_mem_weM,
  input  logic [2:0]  i_mem_funct3M,
  input  logic [31:0] i_mem_addrM,
  input  logic [31:0] i_mem_wdataM,
  output logic [31:0] o_mem_rdataM,
  output logic        o_bus_stallM,
  output logic        o_faultM,
  output logic        o_bus_errM,
  riscv_dbus_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        legal, start, rsp_take, tmo_hit, tmo_abort;
  logic        we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("riscv_dbus_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  // funct3[1:0] is the size, funct3[2] the unsigned flag (loads only)
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    if (f3[2] && (we || f3[1])) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] lane;
    lane = w >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{lane[7]}}, lane[7:0]};
      3'b001:  return {{16{lane[15]}}, lane[15:0]};
      3'b100:  return {24'd0, lane[7:0]};
      3'b101:  return {16'd0, lane[15:0]};
      default: return w;
    endcase
  endfunction

  assign legal    = access_legal(i_mem_weM, i_mem_funct3M, i_mem_addrM[1:0]);
  assign start    = (state_q == S_IDLE) && i_mem_reqM && legal;
  assign rsp_take = (state_q == S_WAIT) && bus.i_bus_rvalid;

`ifdef RISCV_DBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_REQ || state_q == S_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Hit on the last allowed cycle so DONE follows exactly TIMEOUT_CYCLES cycles of REQ+WAIT
  assign tmo_hit = (state_q == S_REQ || state_q == S_WAIT) &&
                   (tmo_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign tmo_abort = tmo_hit && (((state_q == S_REQ) && !bus.i_bus_gnt) ||
                                 ((state_q == S_WAIT) && !bus.i_bus_rvalid));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        if (bus.i_bus_gnt)  state_d = S_WAIT;
        else if (tmo_abort) state_d = S_DONE;
      end
      S_WAIT: begin
        if (bus.i_bus_rvalid) state_d = S_DONE;
        else if (tmo_abort)   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture in IDLE, response capture in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (start) begin
        addr_q  <= {i_mem_addrM[31:2], 2'b00};
        we_q    <= i_mem_weM;
        be_q    <= byte_en(i_mem_funct3M[1:0], i_mem_addrM[1:0]);
        wdata_q <= store_lanes(i_mem_funct3M[1:0], i_mem_wdataM);
      end
      if (rsp_take) begin
        rdata_q <= we_q ? 32'd0 : load_align(f3_q, off_q, bus.i_bus_rdata);
        err_q   <= bus.i_bus_err;
      end else if (tmo_abort) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      f3_q  <= i_mem_funct3M;
      off_q <= i_mem_addrM[1:0];
    end
  end

  assign bus.o_bus_req   = (state_q == S_REQ);
  assign bus.o_bus_we    = we_q;
  assign bus.o_bus_addr  = addr_q;
  assign bus.o_bus_be    = be_q;
  assign bus.o_bus_wdata = wdata_q;

  assign o_mem_rdataM = rdata_q;
  assign o_bus_errM   = (state_q == S_DONE) && err_q;
  assign o_faultM     = (state_q == S_IDLE) && i_mem_reqM && !legal;
  assign o_bus_stallM = i_mem_reqM && legal && (state_q != S_DONE);

endmodule

// File: tb/tb_riscv_dbus_ctrl.sv
// Bench for riscv_dbus_ctrl: directed vector table, corner sequences, randomized accesses vs a model.
module tb_riscv_dbus_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we;
  logic [2:0]  mem_f3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, fault, bus_err;
  int          total = 0;
  int          bad = 0;

  riscv_dbus_ctrl_if bus();

  riscv_dbus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_mem_reqM(mem_req), .i_mem_weM(mem_we), .i_mem_funct3M(mem_f3),
    .i_mem_addrM(mem_addr), .i_mem_wdataM(mem_wdata),
    .o_mem_rdataM(mem_rdata), .o_bus_stallM(stall), .o_faultM(fault),
    .o_bus_errM(bus_err), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] addr, wdata, rdata; logic err;
    int gdly, rdly;
    logic x_fault; logic [3:0] x_be; logic [31:0] x_wdata, x_rdata; int x_stalls; logic x_err;
  } vec_t;

  typedef struct {
    logic fault, req_at_fault, timed_out, err, err_early, we;
    int stalls, unstable;
    logic [31:0] rdata, addr, wdata;
    logic [3:0] be;
  } res_t;

  vec_t tbl[13];
  res_t r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---- reference model, computed straight from the access rules ----
  function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz = int'(f3) % 4;
    if (sz == 3) return 1'b0;
    if (we && f3 >= 3) return 1'b0;
    if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b0;
    return (a % (1 << sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = int'(f3) % 4;
    int v;
    if (sz == 2) return 4'hF;
    v = ((1 << (1 << sz)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = int'(f3) % 4;
    if (sz == 0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic we, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] rd);
    int sz = int'(f3) % 4;
    longint lane, v;
    if (we) return 32'd0;
    if (sz == 2) return rd;
    lane = longint'(rd) >> (8 * (a % 4));
    if (sz == 0) begin
      v = lane % 256;
      if (f3 < 4 && v >= 128) v = v - 256;
    end else begin
      v = lane % 65536;
      if (f3 < 4 && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  // Holds one MEM-stage access until stall drops, playing the memory side of the bus.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                            input int gdly, input int rdly, output res_t res);
    int req_n = 0;
    int wait_n = 0;
    bit in_wait = 0;
    bit done = 0;
    res = '{default: '0};
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_f3 = f3; mem_addr = addr; mem_wdata = wdata;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.i_bus_gnt = 1'b0;
      bus.i_bus_rvalid = (cyc == 0) ? 1'($urandom % 2) : 1'b0;
      bus.i_bus_rdata = $urandom;
      bus.i_bus_err = 1'($urandom % 2);
      if (bus.o_bus_req) begin
        if (req_n == 0) begin
          res.addr = bus.o_bus_addr; res.be = bus.o_bus_be;
          res.wdata = bus.o_bus_wdata; res.we = bus.o_bus_we;
        end else if (bus.o_bus_addr !== res.addr || bus.o_bus_be !== res.be ||
                     bus.o_bus_wdata !== res.wdata || bus.o_bus_we !== res.we) begin
          res.unstable++;
        end
        if (req_n == gdly) begin
          bus.i_bus_gnt = 1'b1;
          in_wait = 1;
        end
        req_n++;
      end else if (in_wait) begin
        if (wait_n == rdly) begin
          bus.i_bus_rvalid = 1'b1; bus.i_bus_rdata = rdata; bus.i_bus_err = err;
        end
        wait_n++;
      end
      #1;
      if (fault) res.fault = 1'b1;
      if (cyc == 0) res.req_at_fault = bus.o_bus_req;
      if (!stall) begin
        res.rdata = mem_rdata; res.err = bus_err; res.stalls = cyc;
        done = 1;
        break;
      end
      if (bus_err) res.err_early = 1'b1;
    end
    if (!done) res.timed_out = 1'b1;
  endtask

  task automatic check_res(input string tag, input res_t res, input logic x_fault,
                           input int x_stalls, input logic we, input logic [31:0] addr,
                           input logic [3:0] x_be, input logic [31:0] x_wdata,
                           input logic [31:0] x_rdata, input logic x_err);
    check({tag, "_completes"}, 32'(res.timed_out), 32'd0);
    check({tag, "_fault"}, 32'(res.fault), 32'(x_fault));
    check({tag, "_stalls"}, res.stalls, x_stalls);
    if (x_fault) begin
      check({tag, "_no_req"}, 32'(res.req_at_fault), 32'd0);
    end else begin
      check({tag, "_addr"}, res.addr, addr & 32'hFFFF_FFFC);
      check({tag, "_we"}, 32'(res.we), 32'(we));
      check({tag, "_be"}, 32'(res.be), 32'(x_be));
      if (we) check({tag, "_wdata"}, res.wdata, x_wdata);
      check({tag, "_stable"}, res.unstable, 0);
      check({tag, "_rdata"}, res.rdata, x_rdata);
      check({tag, "_err"}, 32'(res.err), 32'(x_err));
      check({tag, "_err_early"}, 32'(res.err_early), 32'd0);
    end
  endtask

  initial begin
    //            we  f3      addr          wdata          rdata         err g  r  flt be      x_wdata        x_rdata       st x_err
    tbl[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF, 3, 1'b0};
    tbl[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_0000, 1'b0, 0, 0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80, 3, 1'b0};
    tbl[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_0000, 1'b0, 0, 0, 1'b0, 4'b1000, 32'h0,         32'h0000_0080, 3, 1'b0};
    tbl[3]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h5555_5555, 1'b0, 0, 0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0,         3, 1'b0};
    tbl[4]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         1'b0, 0, 0, 1'b1, 4'b0000, 32'h0,         32'h0,         0, 1'b0};
    tbl[5]  = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,         32'h1122_3344, 1'b0, 5, 0, 1'b0, 4'b1111, 32'h0,         32'h1122_3344, 8, 1'b0};
    tbl[6]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h8001_0000, 1'b0, 0, 1, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001, 4, 1'b0};
    tbl[7]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'h8001_0000, 1'b0, 1, 0, 1'b0, 4'b1100, 32'h0,         32'h0000_8001, 4, 1'b0};
    tbl[8]  = '{1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0,         1'b0, 0, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0,         3, 1'b0};
    tbl[9]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 0, 0, 1'b1, 4'b0000, 32'h0,         32'h0,         0, 1'b0};
    tbl[10] = '{1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,         1'b1, 0, 2, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0,         5, 1'b1};
    tbl[11] = '{1'b1, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         1'b0, 0, 0, 1'b1, 4'b0000, 32'h0,         32'h0,         0, 1'b0};
    tbl[12] = '{1'b0, 3'b110, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 0, 0, 1'b1, 4'b0000, 32'h0,         32'h0,         0, 1'b0};

    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_f3 = 3'b0; mem_addr = '0; mem_wdata = '0;
    bus.i_bus_gnt = 1'b0; bus.i_bus_rvalid = 1'b0; bus.i_bus_rdata = '0; bus.i_bus_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(bus.o_bus_req), 32'd0);
    check("rst_we", 32'(bus.o_bus_we), 32'd0);
    check("rst_addr", bus.o_bus_addr, 32'd0);
    check("rst_be", 32'(bus.o_bus_be), 32'd0);
    check("rst_wdata", bus.o_bus_wdata, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // Directed table, issued back-to-back
    for (int i = 0; i < 13; i++) begin
      run_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err,
                 tbl[i].gdly, tbl[i].rdly, r);
      check_res($sformatf("v%0d", i), r, tbl[i].x_fault, tbl[i].x_stalls, tbl[i].we,
                tbl[i].addr, tbl[i].x_be, tbl[i].x_wdata, tbl[i].x_rdata, tbl[i].x_err);
    end

    // Fault must not linger once the illegal request goes away
    run_access(1'b0, 3'b010, 32'h0000_0011, 32'h0, 32'h0, 1'b0, 0, 0, r);
    check("fault_pulse", 32'(r.fault), 32'd1);
    @(negedge clk);
    mem_req = 1'b0;
    #1;
    check("fault_drop", 32'(fault), 32'd0);
    check("fault_no_req", 32'(bus.o_bus_req), 32'd0);

    // Reset during WAIT, then a late rvalid that must be discarded
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_f3 = 3'b010; mem_addr = 32'h40;
    @(negedge clk);
    bus.i_bus_gnt = 1'b1;
    #1;
    check("mid_req_high", 32'(bus.o_bus_req), 32'd1);
    @(negedge clk);
    bus.i_bus_gnt = 1'b0; rst = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.o_bus_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    bus.i_bus_rvalid = 1'b1; bus.i_bus_rdata = 32'h0BAD_0BAD; bus.i_bus_err = 1'b1;
    @(negedge clk);
    bus.i_bus_rvalid = 1'b0; bus.i_bus_err = 1'b0;
    #1;
    check("late_rvalid_err", 32'(bus_err), 32'd0);
    check("late_rvalid_req", 32'(bus.o_bus_req), 32'd0);
    check("late_rvalid_stall", 32'(stall), 32'd0);
    run_access(1'b0, 3'b010, 32'h0000_0080, 32'h0, 32'h1357_9BDF, 1'b0, 0, 0, r);
    check_res("after_rst", r, 1'b0, 3, 1'b0, 32'h80, 4'hF, 32'h0, 32'h1357_9BDF, 1'b0);

`ifdef RISCV_DBUS_TIMEOUT_EN
    // rvalid never arrives: 1 IDLE cycle + 8 timeout cycles of stall
    run_access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 1'b0, 1, 1000, r);
    check("tmo_completes", 32'(r.timed_out), 32'd0);
    check("tmo_stalls", r.stalls, 9);
    check("tmo_err", 32'(r.err), 32'd1);
    check("tmo_rdata", r.rdata, 32'd0);
`endif

    // Randomized accesses against the model
    for (int i = 0; i < 60; i++) begin
      logic        rwe, rerr, lg;
      logic [2:0]  rf3;
      logic [31:0] ra, rwd, rrd;
      int          gd, rd;
      rwe = 1'($urandom % 2); rf3 = 3'($urandom % 8);
      ra = $urandom; rwd = $urandom; rrd = $urandom;
      rerr = ($urandom % 8) == 0;
      gd = int'($urandom % 4); rd = int'($urandom % 4);
      lg = m_legal(rwe, rf3, ra);
      run_access(rwe, rf3, ra, rwd, rrd, rerr, gd, rd, r);
      check_res($sformatf("rnd%0d", i), r, !lg, lg ? 3 + gd + rd : 0, rwe, ra,
                m_be(rf3, ra), m_wdata(rf3, rwd), m_load(rwe, rf3, ra, rrd), rerr);
    end

    @(negedge clk);
    mem_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
